// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
// I2C target with a byte-pointer register file. SCL/SDA are oversampled on HCLK.
// A bus write sends a pointer byte and then data bytes. A bus read returns data from the pointer and auto-increments it.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned AW         = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] loc_raddr,
  output logic [7:0]    loc_rdata,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK,
    S_IGNORE
  } state_t;

  state_t        state;
  logic          scl_s1, scl_s2, scl_d;
  logic          sda_s1, sda_s2, sda_d;
  logic          scl_rise, scl_fall, sda_rise, sda_fall;
  logic          start_c, stop_c;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte;
  logic [2:0]    cnt;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [NUM_REGS];

  // Synchronizers idle high so a reset does not fabricate a bus edge
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    sda_rise  = sda_s2 & ~sda_d;
    sda_fall  = ~sda_s2 & sda_d;
    start_c   = sda_fall & scl_s2;
    stop_c    = sda_rise & scl_s2;
    rx_byte   = {shreg[6:0], sda_s2};
    loc_rdata = regs[loc_raddr];
  end

  // The ACK states hand over on the 9th SCL rise. That way the falling edge that ends
  // the ACK either releases SDA (receive states) or drives the first read bit (S_RDATA).
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      ptr      <= '0;
      shreg    <= '0;
      cnt      <= '0;
      rw       <= 1'b0;
      regs     <= '{default: '0};
    end else begin
      wr_valid <= 1'b0;
      if (stop_c) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_c) begin
        state  <= S_ADDR;
        sda_oe <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              shreg <= rx_byte;
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (state == S_ADDR) begin
                  rw <= sda_s2;
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state <= S_ADDR_ACK;
                    busy  <= 1'b1;
                  end else begin
                    state <= S_IGNORE;
                    busy  <= 1'b0;
                  end
                end else if (state == S_PTR) begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= S_PTR_ACK;
                end else begin
                  state <= S_WDATA_ACK;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) sda_oe <= 1'b1;
            if (scl_rise) begin
              cnt <= '0;
              if (rw) begin
                shreg <= regs[ptr];
                ptr   <= ptr + 1'b1;
                state <= S_RDATA;
              end else begin
                state <= S_PTR;
              end
            end
          end
          S_PTR_ACK: begin
            if (scl_fall) sda_oe <= 1'b1;
            if (scl_rise) begin
              cnt   <= '0;
              state <= S_WDATA;
            end
          end
          S_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe     <= 1'b1;
              regs[ptr]  <= shreg;
              wr_valid   <= 1'b1;
              wr_addr    <= ptr;
              wr_data    <= shreg;
              ptr        <= ptr + 1'b1;
            end
            if (scl_rise) begin
              cnt   <= '0;
              state <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              sda_oe <= ~shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
            end
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                cnt   <= '0;
                state <= S_RACK;
              end
            end
          end
          S_RACK: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              if (!sda_s2) begin
                shreg <= regs[ptr];
                ptr   <= ptr + 1'b1;
                state <= S_RDATA;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_IGNORE: sda_oe <= 1'b0;
          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
// Bench for i2c_slave_regfile: a bus master issues random and directed transactions against an array model.
// Write pulses and read bytes are checked through scoreboard queues.
module tb_i2c_slave_regfile;

  localparam int unsigned Q = 50;  // quarter SCL period in ns (SCL = 20 HCLK)

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] loc_raddr = '0;
  logic [3:0] wr_addr;
  logic [7:0] loc_rdata, wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .AW(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .loc_raddr(loc_raddr), .loc_rdata(loc_rdata), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0]  mem [16];
  int unsigned mptr;
  wr_t         exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  got_rd_q[$];
  logic [7:0]  dbuf [8];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  bit          oe_seen = 0;
  bit          busy_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Scoreboard monitor: consumes DUT write pulses and bytes read off the bus
  always @(negedge HCLK) begin
    wr_t        e;
    logic [7:0] g;
    if (sda_oe) oe_seen = 1;
    if (busy) busy_seen = 1;
    if (wr_valid) begin
      if (exp_wr_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL wr_unexpected got addr=%0h data=%0h exp=none", wr_addr, wr_data);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
    if (got_rd_q.size() > 0) begin
      g = got_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL rd_unexpected got=%0h exp=none", g);
      end else begin
        check("rd_byte", {24'd0, g}, {24'd0, exp_rd_q.pop_front()});
      end
    end
  end

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    b = sda_bus; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic txn_write(input logic [7:0] p, input int unsigned n);
    logic ack;
    bus_start();
    put_byte(8'hA0, ack); check("addr_ack_w", {31'd0, ack}, 32'd0);
    put_byte(p, ack);     check("ptr_ack", {31'd0, ack}, 32'd0);
    mptr = p % 16;
    for (int unsigned i = 0; i < n; i++) begin
      exp_wr_q.push_back(wr_t'{a: mptr[3:0], d: dbuf[i]});
      mem[mptr] = dbuf[i];
      mptr = (mptr + 1) % 16;
      put_byte(dbuf[i], ack); check("data_ack", {31'd0, ack}, 32'd0);
    end
    bus_stop();
  endtask

  task automatic txn_read(input bit set_ptr, input logic [7:0] p, input int unsigned n);
    logic       ack;
    logic [7:0] v;
    bus_start();
    if (set_ptr) begin
      put_byte(8'hA0, ack); check("addr_ack_w", {31'd0, ack}, 32'd0);
      put_byte(p, ack);     check("ptr_ack", {31'd0, ack}, 32'd0);
      mptr = p % 16;
      bus_start();
    end
    put_byte(8'hA1, ack); check("addr_ack_r", {31'd0, ack}, 32'd0);
    for (int unsigned i = 0; i < n; i++) begin
      exp_rd_q.push_back(mem[mptr]);
      mptr = (mptr + 1) % 16;
      get_byte(v, (i == n - 1));
      got_rd_q.push_back(v);
    end
    bus_stop();
  endtask

  task automatic check_reg(input string name, input int unsigned r);
    loc_raddr = r[3:0];
    #1;
    check(name, {24'd0, loc_rdata}, {24'd0, mem[r]});
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] v;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 0;
    #22 HRESET = 1'b0;
    #28;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_reg("rst_reg0", 0);

    // Basic write, then a current-address read to confirm the pointer landed on 5
    busy_seen = 0;
    dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
    txn_write(8'h03, 2);
    check("wr_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    check_reg("wr_reg3", 3);
    check_reg("wr_reg4", 4);
    txn_read(1'b0, 8'h00, 1);

    // Address mismatch: the target stays silent
    oe_seen = 0; busy_seen = 0;
    bus_start();
    put_byte(8'hA2, ack); check("mismatch_nack", {31'd0, ack}, 32'd1);
    put_byte(8'h55, ack); check("mismatch_data_nack", {31'd0, ack}, 32'd1);
    bus_stop();
    check("mismatch_oe", {31'd0, oe_seen}, 32'd0);
    check("mismatch_busy", {31'd0, busy_seen}, 32'd0);

    // Repeated-start read that wraps the pointer from 15 to 0
    dbuf[0] = 8'h3C; txn_write(8'h0F, 1);
    dbuf[0] = 8'hC3; txn_write(8'h00, 1);
    txn_read(1'b1, 8'h0F, 2);
    txn_read(1'b0, 8'h00, 1);

    // Master NACK puts the target in ignore until the next START
    bus_start();
    put_byte(8'hA1, ack); check("nack_addr_ack", {31'd0, ack}, 32'd0);
    exp_rd_q.push_back(mem[mptr]);
    mptr = (mptr + 1) % 16;
    get_byte(v, 1'b1);
    got_rd_q.push_back(v);
    oe_seen = 0;
    for (int i = 0; i < 9; i++) get_bit(ack);
    check("ignore_oe", {31'd0, oe_seen}, 32'd0);
    bus_start();
    put_byte(8'hA0, ack); check("after_ignore_ack", {31'd0, ack}, 32'd0);
    bus_stop();

    // A partial data byte cut short by STOP is discarded
    dbuf[0] = 8'h77; txn_write(8'h02, 1);
    bus_start();
    put_byte(8'hA0, ack); check("abort_addr_ack", {31'd0, ack}, 32'd0);
    put_byte(8'h02, ack); check("abort_ptr_ack", {31'd0, ack}, 32'd0);
    mptr = 2;
    for (int i = 0; i < 4; i++) put_bit(1'($urandom_range(0, 1)));
    bus_stop();
    check_reg("abort_reg2", 2);
    check("abort_busy", {31'd0, busy}, 32'd0);
    txn_read(1'b0, 8'h00, 1);

    // Random mix of writes, pointer-set reads and current-address reads
    for (int it = 0; it < 16; it++) begin
      int unsigned kind, n;
      logic [7:0]  p;
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      p    = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        for (int unsigned i = 0; i < n; i++) dbuf[i] = 8'($urandom);
        txn_write(p, n);
      end else begin
        txn_read(kind == 1, p, n);
      end
    end

    // Reset while the target is driving the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
    check("ack_oe_before_rst", {31'd0, sda_oe}, 32'd1);
    HRESET = 1'b1;
    #1;
    check("rst_async_oe", {31'd0, sda_oe}, 32'd0);
    #11 HRESET = 1'b0;
    #38;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 0;
    check("rst2_busy", {31'd0, busy}, 32'd0);
    check_reg("rst2_reg3", 3);
    for (int unsigned i = 0; i < 3; i++) dbuf[i] = 8'($urandom);
    txn_write(8'($urandom_range(0, 15)), 3);
    txn_read(1'b1, 8'($urandom_range(0, 15)), 3);

    for (int unsigned r = 0; r < 16; r++) check_reg("final_reg", r);
    #(10*Q);
    check("exp_wr_left", exp_wr_q.size(), 32'd0);
    check("exp_rd_left", exp_rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target (slave) on the shared open-drain SCL/SDA bus, opposite the SoC's I2C master. It is the consumer of every master transaction.
- Oversamples SCL/SDA on HCLK, detects START/STOP, matches a 7-bit address, and serves a byte-pointer register file.
- Protocol: write = pointer byte followed by data bytes; read = data from the current pointer, auto-incrementing.
- Local side gets a write-strobe interface and an asynchronous read port.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address answered.
- NUM_REGS, 16, number of 8-bit registers; power of two, 2..256.
- AW, 4, pointer width = log2(NUM_REGS).

Ports:
- HCLK  input  1  system clock; must be ≥16× SCL frequency.
- HRESET  input  1  asynchronous, active-high reset.
- scl_in  input  1  SCL pin level.
- sda_in  input  1  SDA pin level.
- sda_oe  output  1  1 = drive SDA low; 0 = release.
- loc_raddr  input  AW  local read address.
- loc_rdata  output  8  reg[loc_raddr], combinational.
- wr_valid  output  1  one-HCLK pulse per bus data byte written.
- wr_addr  output  AW  register index of that write.
- wr_data  output  8  byte written.
- busy  output  1  high from address match to STOP/abort.

Behaviour:
- Reset (async, HRESET=1):
  - sda_oe=0, wr_valid=0, busy=0, wr_addr=0, wr_data=0.
  - Pointer=0, all registers=8'h00, state=IDLE.
  - Synchronizer flops reset to 1 (bus idle).
- Input path:
  - 2-flop synchronizer on scl_in and sda_in, then one previous-value flop.
  - Edge events (scl_rise, scl_fall, sda_rise, sda_fall) are valid 3 HCLK after the pin change.
- Bus conditions:
  - START = sda_fall while synced SCL=1.
  - STOP = sda_rise while synced SCL=1.
  - Both take priority over data sampling in the same cycle.
- Bit timing:
  - Sample SDA on scl_rise.
  - Update sda_oe on scl_fall, so bus SDA changes only while SCL is low.
  - 3-bit bit counter; bytes are MSB first.
- States and transitions:
  - IDLE: START → ADDR (counter=0).
  - ADDR: shift 8 bits. After the 8th bit, address match → ADDR_ACK; mismatch → IGNORE.
  - ADDR_ACK: sda_oe=1 for the 9th SCL clock; busy=1. R/W=0 → PTR. R/W=1 → load shift register from reg[ptr], ptr=ptr+1, then RDATA.
  - PTR: 8 bits; the low AW bits are loaded into ptr, upper bits are ignored. Then → PTR_ACK (ACK driven) → WDATA.
  - WDATA: 8 bits → WDATA_ACK (ACK driven). On the scl_fall that begins the ACK, write reg[ptr], pulse wr_valid with wr_addr=ptr and wr_data=byte, then ptr=ptr+1. Then → WDATA.
  - RDATA: on each scl_fall, sda_oe = ~shift[7], then shift left. After 8 bits, release SDA → RACK.
  - RACK: sample master ACK on scl_rise. ACK(0) → reload from reg[ptr], ptr++, → RDATA. NACK(1) → IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Global event handling:
  - STOP in any state → IDLE, sda_oe=0, busy=0 on the next HCLK.
  - START in any state (repeated start) → ADDR; ptr is kept.
  - A partial byte at STOP/START is discarded: no write, ptr unchanged.
- Pointer wraps modulo NUM_REGS (e.g. ptr 15 +1 → 0).
- loc_rdata during a same-cycle bus write returns the old value.
- Reset mid-transfer: SDA is released immediately (asynchronously) and the FSM returns to IDLE.

Test Plan:
- Write: START, 0xA0 ACK, 0x03 ACK, 0xA5 ACK, 0x5A ACK, STOP → reg[3]=A5, reg[4]=5A. Two wr_valid pulses (addr 3, then 4); ptr=5; busy falls after STOP.
- Mismatch: START, 0xA2 (addr 0x51), 8 clocks, STOP → sda_oe stays 0 throughout; no wr_valid; busy stays 0.
- Repeated-start read with wrap:
  - Preload reg[15]=0x3C, reg[0]=0xC3.
  - START, 0xA0, 0x0F, Sr, 0xA1, then read 2 bytes (ACK, then NACK), STOP.
  - Bus sees 0x3C then 0xC3; ptr=1.
- Master NACK: read 1 byte, master NACK, 9 more SCL clocks with no START → sda_oe stays 0 (IGNORE); next START is accepted.
- Abort: START, 0xA0, 0x02, 4 data bits, STOP → reg[2] unchanged; no wr_valid; state IDLE.
- Reset: assert HRESET while sda_oe=1 during an ACK → sda_oe=0 within the same cycle; after release, a full write transaction succeeds.
